// File: rtl/multicycle_controller.sv
// Multicycle control FSM for an RV32I subset covering R/I ALU ops and BEQ/BNE.
// An ALU op takes 4 cycles and a branch 3; undecodable instructions park in TRAP until reset.
module multicycle_controller #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         instruction,
  input  logic                alu_zero,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                reg_write_enable,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [4:0]          rd,
  output logic [2:0]          alu_op,
  output logic                alu_src_b,
  output logic [11:0]         imm,
  output logic [12:0]         branch_offset,
  output logic [2:0]          state,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_WRITEBACK = 3'd3;
  localparam logic [2:0] S_BRANCH    = 3'd4;
  localparam logic [2:0] S_TRAP      = 3'd5;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  logic [2:0]          state_q, state_d;
  logic [31:0]         ir_q, ir_d;
  logic                illegal_q, illegal_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_r;
  logic       is_i;
  logic       alu_legal;
  logic       br_legal;
  logic [2:0] dec_alu_op;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];
  assign is_r   = (opcode == OPC_R);
  assign is_i   = (opcode == OPC_I);

  assign rs1           = ir_q[19:15];
  assign rs2           = ir_q[24:20];
  assign rd            = ir_q[11:7];
  assign imm           = ir_q[31:20];
  assign branch_offset = {ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

  // Shifts are the only I-type ops whose upper immediate bits are constrained.
  always_comb begin
    dec_alu_op = OP_ADD;
    alu_legal  = 1'b0;
    case (funct3)
      3'b000: begin
        if (is_r && funct7 == 7'b0100000) begin
          dec_alu_op = OP_SUB;
          alu_legal  = 1'b1;
        end else begin
          dec_alu_op = OP_ADD;
          alu_legal  = is_i || (is_r && funct7 == 7'b0);
        end
      end
      3'b111: begin dec_alu_op = OP_AND; alu_legal = is_i || (is_r && funct7 == 7'b0); end
      3'b110: begin dec_alu_op = OP_OR;  alu_legal = is_i || (is_r && funct7 == 7'b0); end
      3'b100: begin dec_alu_op = OP_XOR; alu_legal = is_i || (is_r && funct7 == 7'b0); end
      3'b010: begin dec_alu_op = OP_SLT; alu_legal = is_i || (is_r && funct7 == 7'b0); end
      3'b001: begin dec_alu_op = OP_SLL; alu_legal = (is_i || is_r) && funct7 == 7'b0; end
      3'b101: begin dec_alu_op = OP_SRL; alu_legal = (is_i || is_r) && funct7 == 7'b0; end
      default: begin dec_alu_op = OP_ADD; alu_legal = 1'b0; end
    endcase
  end

  assign br_legal = (opcode == OPC_B) && (funct3 == 3'b000 || funct3 == 3'b001);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ir_q      <= 32'd0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = S_DECODE;
      S_DECODE: begin
        if (alu_legal)     state_d = S_EXECUTE;
        else if (br_legal) state_d = S_BRANCH;
        else               state_d = S_TRAP;
      end
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ir_d      = (state_q == S_FETCH) ? instruction : ir_q;
    illegal_d = illegal_q | (state_d == S_TRAP);
    retired_d = retired_q;
    if (state_q == S_WRITEBACK || state_q == S_BRANCH) begin
      retired_d = retired_q + RETIRE_W'(1);
    end
  end

  // Strobes are gated by reset so nothing fires while the block is being cleared.
  always_comb begin
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_src           = 1'b0;
    reg_write_enable = 1'b0;
    alu_op           = OP_ADD;
    alu_src_b        = 1'b0;
    case (state_q)
      S_FETCH: ir_write = !reset;
      S_EXECUTE: begin
        alu_op    = dec_alu_op;
        alu_src_b = is_i;
      end
      S_WRITEBACK: begin
        alu_op           = dec_alu_op;
        alu_src_b        = is_i;
        reg_write_enable = !reset && (rd != 5'd0);
        pc_write         = !reset;
      end
      S_BRANCH: begin
        alu_op   = OP_SUB;
        pc_write = !reset;
        pc_src   = (funct3 == 3'b000) ? alu_zero : !alu_zero;
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller against an instruction-level reference model.
module tb_multicycle_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        alu_zero;
  logic        ir_write, pc_write, pc_src, reg_write_enable, alu_src_b, illegal;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  alu_op, state;
  logic [11:0] imm;
  logic [12:0] branch_offset;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_retired;

  multicycle_controller #(.RETIRE_W(32)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .alu_zero(alu_zero),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write_enable(reg_write_enable), .rs1(rs1), .rs2(rs2), .rd(rd),
    .alu_op(alu_op), .alu_src_b(alu_src_b), .imm(imm), .branch_offset(branch_offset),
    .state(state), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic no_strobes(input string tag);
    check({tag, "_irw"}, 32'(ir_write), 32'd0);
    check({tag, "_pcw"}, 32'(pc_write), 32'd0);
    check({tag, "_rwe"}, 32'(reg_write_enable), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    no_strobes("rst_hi");
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_ir", {rs1, rs2, rd, imm}, 32'd0);
    no_strobes("rst_after");
    reset = 1'b0;
    exp_retired = 32'd0;
  endtask

  // Instruction-level model: kind 0 = illegal, 1 = R-type, 2 = I-type, 3 = branch.
  task automatic run_instr(input logic [31:0] ins, input logic az, input bit rst_in_exec);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    int kind;
    int exp_op;
    int op_tbl[8];
    op_tbl = '{0, 5, 7, 0, 4, 6, 3, 2};
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    kind = 0;
    exp_op = op_tbl[f3];
    if (opc == 7'b0110011) begin
      if ((f7 == 7'd0 && f3 != 3'd3) || (f7 == 7'h20 && f3 == 3'd0)) kind = 1;
      if (f7 == 7'h20) exp_op = 1;
    end else if (opc == 7'b0010011) begin
      if (f3 == 1 || f3 == 5) begin
        if (f7 == 7'd0) kind = 2;
      end else if (f3 != 3) begin
        kind = 2;
      end
    end else if (opc == 7'b1100011 && f3 <= 3'd1) begin
      kind = 3;
    end

    instruction = ins;
    alu_zero = az;
    #1;
    check("fetch_state", 32'(state), 32'd0);
    check("fetch_irw", 32'(ir_write), 32'd1);
    check("fetch_pcw", 32'(pc_write), 32'd0);
    check("fetch_rwe", 32'(reg_write_enable), 32'd0);
    check("fetch_retired", retired, exp_retired);
    tick();

    instruction = $urandom;
    #1;
    check("dec_state", 32'(state), 32'd1);
    no_strobes("dec");
    check("dec_rs1", 32'(rs1), 32'(ins[19:15]));
    check("dec_rs2", 32'(rs2), 32'(ins[24:20]));
    check("dec_rd", 32'(rd), 32'(ins[11:7]));
    check("dec_imm", 32'(imm), 32'(ins[31:20]));
    check("dec_boff", 32'(branch_offset),
          32'(ins[31]) * 4096 + 32'(ins[7]) * 2048 + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2);
    tick();

    if (kind == 0) begin
      for (int i = 0; i < 3; i++) begin
        check("trap_state", 32'(state), 32'd5);
        check("trap_illegal", 32'(illegal), 32'd1);
        check("trap_retired", retired, exp_retired);
        no_strobes("trap");
        tick();
      end
      do_reset();
    end else if (kind == 3) begin
      check("br_state", 32'(state), 32'd4);
      check("br_aluop", 32'(alu_op), 32'd1);
      check("br_srcb", 32'(alu_src_b), 32'd0);
      check("br_pcw", 32'(pc_write), 32'd1);
      check("br_pcsrc", 32'(pc_src), 32'((f3 == 3'd0) ? az : !az));
      check("br_rwe", 32'(reg_write_enable), 32'd0);
      check("br_irw", 32'(ir_write), 32'd0);
      tick();
      exp_retired = exp_retired + 1;
    end else begin
      check("ex_state", 32'(state), 32'd2);
      check("ex_aluop", 32'(alu_op), 32'(exp_op));
      check("ex_srcb", 32'(alu_src_b), 32'(kind == 2));
      no_strobes("ex");
      if (rst_in_exec) begin
        reset = 1'b1;
        #1;
        no_strobes("exrst_hi");
        tick();
        check("exrst_state", 32'(state), 32'd0);
        check("exrst_retired", retired, 32'd0);
        no_strobes("exrst_after");
        reset = 1'b0;
        exp_retired = 32'd0;
        return;
      end
      tick();
      check("wb_state", 32'(state), 32'd3);
      check("wb_aluop", 32'(alu_op), 32'(exp_op));
      check("wb_srcb", 32'(alu_src_b), 32'(kind == 2));
      check("wb_rwe", 32'(reg_write_enable), 32'(ins[11:7] != 5'd0));
      check("wb_pcw", 32'(pc_write), 32'd1);
      check("wb_pcsrc", 32'(pc_src), 32'd0);
      check("wb_irw", 32'(ir_write), 32'd0);
      tick();
      exp_retired = exp_retired + 1;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  f7;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: begin
        case ($urandom_range(0, 2))
          0: f7 = 7'h00;
          1: f7 = 7'h20;
          default: f7 = 7'($urandom);
        endcase
        r = {f7, r[24:7], 7'b0110011};
      end
      1: begin
        r[6:0] = 7'b0010011;
        if ($urandom_range(0, 1) == 1) r[31:25] = 7'd0;
      end
      2: begin
        r[6:0] = 7'b1100011;
        r[14:12] = 3'($urandom_range(0, 3));
      end
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    reset = 1'b1;
    instruction = 32'd0;
    alu_zero = 1'b0;
    exp_retired = 32'd0;
    tick();
    do_reset();

    run_instr(32'h005303B3, 1'b0, 1'b0);
    check("add_retired", retired, 32'd1);
    run_instr(32'h00628463, 1'b1, 1'b0);
    check("beq_boff", 32'(branch_offset), 32'd8);
    run_instr(32'h00628463, 1'b0, 1'b0);
    run_instr(32'h00508013, 1'b0, 1'b0);
    run_instr(32'h40530333, 1'b0, 1'b0);
    run_instr(32'h005303B3, 1'b0, 1'b1);
    run_instr(32'h00000000, 1'b0, 1'b0);
    run_instr(32'h40535393, 1'b0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      run_instr(rand_instr(), 1'($urandom), ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter RETIRE_W, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 instruction  input  32  instruction-memory output for the current pc.
REQ-005 alu_zero  input  1  high when the ALU result is 0; valid during BRANCH.
REQ-006 ir_write  output  1  high for one cycle: the controller latches instruction into its internal IR.
REQ-007 pc_write  output  1  high for one cycle: the pc register loads its next value.
REQ-008 pc_src  output  1  pc next-value select: 0 = pc+4, 1 = pc+sext(branch_offset).
REQ-009 reg_write_enable  output  1  register-file write strobe.
REQ-010 rs1, rs2, rd  output  5 each  register indices decoded from IR.
REQ-011 alu_op  output  3  ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SLT=7.
REQ-012 alu_src_b  output  1  ALU b select: 0 = register rs2, 1 = sign-extended imm.
REQ-013 imm  output  12  I-type immediate, IR[31:20].
REQ-014 branch_offset  output  13  B-type offset {IR[31],IR[7],IR[30:25],IR[11:8],1'b0}.
REQ-015 state  output  3  current FSM state encoding.
REQ-016 illegal  output  1  sticky trap flag.
REQ-017 retired  output  RETIRE_W  count of completed instructions.

Function
REQ-018 The FSM SHALL use these states and encodings: FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3, BRANCH=4, TRAP=5; all other codes go to FETCH on the next edge.
REQ-019 FETCH SHALL assert ir_write for one cycle and go to DECODE; the IR updates only on ir_write.
REQ-020 DECODE SHALL classify IR and transition as follows: opcode 0110011 or 0010011 with a legal funct -> EXECUTE; opcode 1100011 with funct3 000 (BEQ) or 001 (BNE) -> BRANCH; anything else -> TRAP.
REQ-021 Legal R-type (funct3/funct7) SHALL be: 000/0000000 ADD, 000/0100000 SUB, 111/0 AND, 110/0 OR, 100/0 XOR, 001/0 SLL, 101/0 SRL, 010/0 SLT; all others (including SLTU and SRA) SHALL be illegal.
REQ-022 Legal I-type SHALL be: funct3 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT, plus 001/101 with IR[31:25]=0 (SLL/SRL); all others SHALL be illegal.
REQ-023 EXECUTE SHALL drive alu_op per REQ-021/022 and alu_src_b = 1 for I-type, 0 for R-type, then go to WRITEBACK.
REQ-024 In WRITEBACK, alu_op and alu_src_b SHALL be held from EXECUTE; reg_write_enable = 1 unless rd == 0; pc_write = 1; pc_src = 0; retired increments; next state is FETCH.
REQ-025 BRANCH SHALL drive alu_op = SUB, alu_src_b = 0, pc_write = 1, and pc_src = alu_zero for BEQ or !alu_zero for BNE; it SHALL NOT write the register file; retired increments; next state is FETCH.
REQ-026 TRAP SHALL set illegal = 1 and hold there until reset, with pc_write, reg_write_enable and ir_write at 0 and retired frozen.
REQ-027 rs1, rs2, rd, imm and branch_offset SHALL be combinational slices of IR, valid from DECODE onward.
REQ-028 The strobes ir_write, pc_write and reg_write_enable SHALL be mutually consistent with the state: never asserted outside the states named above, and each asserted for at most one cycle per instruction.
REQ-029 Latency SHALL be 4 cycles per ALU instruction and 3 cycles per branch.
REQ-030 retired SHALL wrap modulo 2^RETIRE_W without a flag.

Reset
REQ-031 While reset is high: state = FETCH, IR = 0, illegal = 0, retired = 0, and all strobes are 0.
REQ-032 Reset asserted in any state, including mid-instruction or TRAP, SHALL abort that instruction with no write; the first post-reset cycle is FETCH.

Verification
REQ-033 Release reset, instruction = 0x005303B3 (add x7,x6,x5) -> DECODE, EXECUTE with alu_op=0 and alu_src_b=0, then WRITEBACK with rs1=6, rs2=5, rd=7, reg_write_enable=1, pc_write=1; retired=1 after 4 cycles.
REQ-034 Instruction = 0x00000000 -> TRAP on the third edge, illegal=1, no strobes thereafter, retired unchanged.
REQ-035 BEQ 0x00628463 with alu_zero=1 -> BRANCH, pc_src=1, branch_offset=8; repeat with alu_zero=0 -> pc_src=0.
REQ-036 addi x0,x1,5 (0x00508013) -> WRITEBACK with reg_write_enable=0, pc_write=1, imm=5.
REQ-037 Reset asserted during EXECUTE -> no reg_write_enable pulse, state=FETCH, retired=0.
REQ-038 Instruction 0x40535393 (SRA, I-type) -> TRAP; instruction 0x40530333 (SUB) -> alu_op=1.
